div_iter_unit: RTL and testbench

// - Parametrised iterative radix-2 divider; successor to the fixed 32-bit EXE-stage divider.
// - Adds valid/ready handshakes on input and output, flush for pipeline cancel, and defined results for divide-by-zero.
// - Sits beside exe_stage and serves div.w/mod.w and div.wu/mod.wu.
// - Quotient and remainder come out together; EXE stalls while busy.

---
 rtl/div_iter_unit_pkg.sv | 13 +
 rtl/div_iter_unit_step.sv | 28 ++
 rtl/div_iter_unit.sv | 120 ++++++++++++
 tb/tb_div_iter_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_unit_pkg.sv
// Shared types and defaults for the iterative divider (div_iter_unit).
// Optional early-out path is enabled by defining DIV_EARLY_OUT_EN.
package div_iter_unit_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_iter_unit_step.sv
// One restoring radix-2 step on the {rem,quo} shift pair: shift left, compare, subtract.
// Purely combinational so an unrolled divider can chain several copies.
module div_iter_unit_step
  import div_iter_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W:0] rem_sh;
  logic            ge;

  // The partial remainder is DATA_W+1 bits wide while shifted, so the compare
  // cannot overflow; after a subtract the result is below the divisor and fits
  // back into DATA_W bits, making a DATA_W-bit modular subtract exact.
  always_comb begin
    rem_sh   = {rem, quo[DATA_W-1]};
    ge       = (rem_sh >= {1'b0, divisor});
    rem_next = ge ? (rem_sh[DATA_W-1:0] - divisor) : rem_sh[DATA_W-1:0];
    quo_next = {quo[DATA_W-2:0], ge};
  end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative radix-2 signed/unsigned divider with valid/ready handshakes and flush.
// Define DIV_EARLY_OUT_EN to finish y==0 and |x|<|y| on the accepting edge.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter  int DATA_W = DIV_DATA_W,
  localparam int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_signed,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_q,
  output logic [DATA_W-1:0] out_r,
  output logic              busy,
  output div_state_e        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; the source holds valid and data until then. in_ready depends
  // only on state and flush; out_valid/out_q/out_r are held until out_ready.

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q, quo_q, div_q;
  logic              neg_q, neg_r;
  logic [DATA_W-1:0] step_rem, step_quo;

  logic              accept;
  logic              x_neg, y_neg, y_zero;
  logic [DATA_W-1:0] x_abs, y_abs;
  logic              early_out;

  always_comb begin
    x_neg  = in_signed & in_x[DATA_W-1];
    y_neg  = in_signed & in_y[DATA_W-1];
    x_abs  = x_neg ? -in_x : in_x;
    y_abs  = y_neg ? -in_y : in_y;
    y_zero = (in_y == '0);
  end

`ifdef DIV_EARLY_OUT_EN
  assign early_out = y_zero || (x_abs < y_abs);
`else
  assign early_out = 1'b0;
`endif

  div_iter_unit_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= DIV_ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == DIV_ST_IDLE) && !flush;
    out_valid = (state_q == DIV_ST_DONE);
    busy      = (state_q != DIV_ST_IDLE);
    dbg_state = state_q;
    accept    = in_valid && in_ready;
    if (flush) begin
      state_d = DIV_ST_IDLE;
    end else begin
      case (state_q)
        DIV_ST_IDLE: if (accept) state_d = early_out ? DIV_ST_DONE : DIV_ST_CALC;
        DIV_ST_CALC: if (cnt_q == '0) state_d = DIV_ST_DONE;
        DIV_ST_DONE: if (out_ready) state_d = DIV_ST_IDLE;
        default:     state_d = DIV_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      out_q <= '0;
      out_r <= '0;
    end else if (accept) begin
      // Magnitudes go in as unsigned; |INT_MIN| is exactly 2^(DATA_W-1).
      cnt_q <= CNT_W'(DATA_W - 1);
      rem_q <= '0;
      quo_q <= x_abs;
      div_q <= y_abs;
      neg_q <= (x_neg ^ y_neg) & ~y_zero;
      neg_r <= x_neg;
      if (early_out) begin
        out_q <= y_zero ? '1 : '0;
        out_r <= in_x;
      end
    end else if (state_q == DIV_ST_CALC && !flush) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        out_q <= neg_q ? -step_quo : step_quo;
        out_r <= neg_r ? -step_rem : step_rem;
      end
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed self-checking bench for div_iter_unit (DATA_W=32), with or without DIV_EARLY_OUT_EN.
module tb_div_iter_unit;
  import div_iter_unit_pkg::*;

  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 0;  // edges after the accepting edge
`else
  localparam int EARLY_LAT = W;
`endif

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_signed = 1'b0;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_q;
  logic [W-1:0] out_r;
  logic         busy;
  div_state_e   dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];

  div_iter_unit #(.DATA_W(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver: present operands for one edge, then scramble them
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    @(negedge clk);
    in_x = x; in_y = y; in_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x = $urandom; in_y = $urandom; in_signed = 1'($urandom_range(0, 1));
  endtask

  // edges after the accepting edge until out_valid; -1 if budget expires
  task automatic wait_done(output int lat);
    lat = -1;
    if (out_valid) lat = 0;
    else begin
      for (int i = 1; i <= 100; i++) begin
        @(posedge clk); #1;
        if (out_valid) begin lat = i; break; end
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_q !== '0) begin n_err++; $display("FAIL reset_out_q got %h want 0", out_q); end
    n_vec++; if (out_r !== '0) begin n_err++; $display("FAIL reset_out_r got %h want 0", out_r); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk); resetn = 1'b1; #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (dbg_state !== DIV_ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d want 0", dbg_state); end
  endtask

  // vectors: x, y, signed, expected q, expected r, early-out eligible
  task automatic test_vectors(input string tag, input int n,
                              input logic [W-1:0] xs[8], input logic [W-1:0] ys[8], input logic ss[8],
                              input logic [W-1:0] qs[8], input logic [W-1:0] rs[8], input logic es[8]);
    int lat;
    logic [2*W-1:0] e;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({qs[i], rs[i]});
      start_op(xs[i], ys[i], ss[i]);
      wait_done(lat);
      e = exp_q.pop_front();
      n_vec++;
      if (lat !== (es[i] ? EARLY_LAT : W)) begin
        n_err++; $display("FAIL %s[%0d]_latency got %0d want %0d", tag, i, lat, es[i] ? EARLY_LAT : W);
      end
      n_vec++;
      if ({out_q, out_r} !== e) begin
        n_err++; $display("FAIL %s[%0d]_result got q=%h r=%h want q=%h r=%h", tag, i, out_q, out_r, e[2*W-1:W], e[W-1:0]);
      end
      consume();
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++; $display("FAIL %s[%0d]_handshake got valid=%b ready=%b want 0/1", tag, i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_unsigned();
    logic [W-1:0] xs[8] = '{32'd100, 32'd12345, 32'hFFFFFFFF, 32'h80000000, 32'd3, 32'd5, 0, 0};
    logic [W-1:0] ys[8] = '{32'd7, 32'd100, 32'd1, 32'hFFFFFFFF, 32'd8, 32'd0, 0, 0};
    logic         ss[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    logic [W-1:0] qs[8] = '{32'd14, 32'd123, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 0, 0};
    logic [W-1:0] rs[8] = '{32'd2, 32'd45, 32'd0, 32'h80000000, 32'd3, 32'd5, 0, 0};
    logic         es[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    test_vectors("unsigned", 6, xs, ys, ss, qs, rs, es);
  endtask

  task automatic test_signed();
    logic [W-1:0] xs[8] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFD, 0};
    logic [W-1:0] ys[8] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd1, 32'd0, 32'd8, 0};
    logic         ss[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic [W-1:0] qs[8] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 0};
    logic [W-1:0] rs[8] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFD, 0};
    logic         es[8] = '{0, 0, 0, 0, 0, 1, 1, 0};
    test_vectors("signed", 7, xs, ys, ss, qs, rs, es);
  endtask

  task automatic test_flush();
    int  lat;
    logic seen;
    start_op(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1; #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1; flush = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_to_idle got busy=%b want 0", busy); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_result got %b want 0", seen); end
    // flush while IDLE must block an offered operation
    @(negedge clk); flush = 1'b1; in_valid = 1'b1; in_x = 32'd50; in_y = 32'd5; in_signed = 1'b0;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_accept got busy=%b want 0", busy); end
    start_op(32'd9, 32'd3, 1'b0);
    wait_done(lat);
    n_vec++; if (lat !== W) begin n_err++; $display("FAIL flush_next_latency got %0d want %0d", lat, W); end
    n_vec++; if (out_q !== 32'd3 || out_r !== 32'd0) begin n_err++; $display("FAIL flush_next_result got q=%h r=%h want q=3 r=0", out_q, out_r); end
    consume();
  endtask

  task automatic test_hold();
    int lat;
    start_op(32'd1000, 32'd33, 1'b0);
    wait_done(lat);
    n_vec++; if (lat !== W) begin n_err++; $display("FAIL hold_latency got %0d want %0d", lat, W); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_q !== 32'd30 || out_r !== 32'd10 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL hold[%0d] got v=%b q=%h r=%h rdy=%b want v=1 q=1e r=a rdy=0", i, out_valid, out_q, out_r, in_ready);
      end
    end
    // offer a new op during the output handshake: it must not be taken
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; in_x = 32'd77; in_y = 32'd7; in_signed = 1'b0;
    @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b0;
    n_vec++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release got busy=%b rdy=%b want 0/1", busy, in_ready); end
  endtask

  task automatic test_reset_mid();
    start_op(32'd12345, 32'd100, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk); #2 resetn = 1'b0; #1;
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_q !== '0 || out_r !== '0) begin
      n_err++; $display("FAIL reset_mid got busy=%b v=%b q=%h r=%h want all 0", busy, out_valid, out_q, out_r);
    end
    @(negedge clk); resetn = 1'b1; #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_mid_ready got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
